// File: rtl/sco_txbuf_pingpong.sv
// sco_txbuf_pingpong: multi-channel SCO/eSCO transmit payload buffer.
// Each channel owns a ping/pong bank pair. The baseband writer fills the
// write bank while the link controller drains the read bank; a tsco_p pulse
// swaps the roles. Pointers auto-increment and per-channel status/error
// flags are kept in one sub-module instance per channel.

// Per-channel pointer, bank-select and sticky flag state.
module sco_txbuf_chan #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_6M,
  input  logic          rst,
  input  logic          swap,
  input  logic          wr_hit,
  input  logic          rd_hit,
  input  logic          err_clr,
  output logic          sel,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] raddr,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          udf,
  output logic          drop
);

  logic [AW:0] wptr, rptr, rlen;
  logic [AW:0] wptr_nx, rptr_nx;
  logic        ovf_set, udf_set, drop_set;

  // rptr never exceeds rlen, so equality is the empty test
  assign full     = (wptr == (AW+1)'(DEPTH));
  assign empty    = (rptr == rlen);
  assign wr_ok    = wr_hit && !full;
  assign rd_ok    = rd_hit && !empty;
  assign waddr    = wptr[AW-1:0];
  assign raddr    = rptr[AW-1:0];
  assign wptr_nx  = wptr + {{AW{1'b0}}, wr_ok};
  assign rptr_nx  = rptr + {{AW{1'b0}}, rd_ok};
  assign ovf_set  = wr_hit && full;
  assign udf_set  = rd_hit && empty;
  // unread words remain if even the same-cycle read leaves rptr short of rlen
  assign drop_set = swap && (rptr_nx != rlen);

  // Pointer advance and bank swap; a coincident write lands in the new read bank
  always_ff @(posedge clk_6M) begin
    if (rst) begin
      sel  <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      rlen <= '0;
    end else if (swap) begin
      sel  <= ~sel;
      rlen <= wptr_nx;
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr_nx;
      rptr <= rptr_nx;
    end
  end

  // Sticky error flags; a set event beats a same-cycle clear
  always_ff @(posedge clk_6M) begin
    if (rst) begin
      ovf  <= 1'b0;
      udf  <= 1'b0;
      drop <= 1'b0;
    end else begin
      ovf  <= ovf_set  | (ovf  & ~err_clr);
      udf  <= udf_set  | (udf  & ~err_clr);
      drop <= drop_set | (drop & ~err_clr);
    end
  end

endmodule

module sco_txbuf_pingpong #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int NCH   = 3,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_6M,
  input  logic           rst,
  input  logic [NCH-1:0] tsco_p,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_ch,
  input  logic [DW-1:0]  wr_data,
  input  logic           rd_en,
  input  logic [CW-1:0]  rd_ch,
  output logic [DW-1:0]  rd_data,
  output logic           rd_valid,
  output logic [NCH-1:0] wr_full,
  output logic [NCH-1:0] rd_empty,
  output logic [NCH-1:0] ovf,
  output logic [NCH-1:0] udf,
  output logic [NCH-1:0] drop,
  input  logic [NCH-1:0] err_clr
);

  localparam int MW = CW + 1 + AW;

  logic [NCH-1:0]         sel, wr_hit, rd_hit, wr_ok, rd_ok;
  logic [NCH-1:0][AW-1:0] waddr, raddr;
  logic                   wr_go, rd_go;
  logic [MW-1:0]          wr_addr, rd_addr;
  logic [DW-1:0]          mem [2**MW];

  // Channel numbers >= NCH match no instance and are silently ignored
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam logic [CW-1:0] CH = CW'(g);
    assign wr_hit[g] = wr_en && (wr_ch == CH);
    assign rd_hit[g] = rd_en && (rd_ch == CH);
    sco_txbuf_chan #(.DEPTH(DEPTH), .AW(AW)) u_chan (
      .clk_6M  (clk_6M),
      .rst     (rst),
      .swap    (tsco_p[g]),
      .wr_hit  (wr_hit[g]),
      .rd_hit  (rd_hit[g]),
      .err_clr (err_clr[g]),
      .sel     (sel[g]),
      .waddr   (waddr[g]),
      .raddr   (raddr[g]),
      .wr_ok   (wr_ok[g]),
      .rd_ok   (rd_ok[g]),
      .full    (wr_full[g]),
      .empty   (rd_empty[g]),
      .ovf     (ovf[g]),
      .udf     (udf[g]),
      .drop    (drop[g])
    );
  end

  // Word address {ch, bank, ptr}; writer uses bank sel, reader bank ~sel
  always_comb begin
    wr_go   = 1'b0;
    wr_addr = '0;
    rd_go   = 1'b0;
    rd_addr = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_ok[c]) begin
        wr_go   = 1'b1;
        wr_addr = {CW'(c), sel[c], waddr[c]};
      end
      if (rd_ok[c]) begin
        rd_go   = 1'b1;
        rd_addr = {CW'(c), ~sel[c], raddr[c]};
      end
    end
  end

  // Payload storage write port, contents deliberately not reset
  always_ff @(posedge clk_6M) begin
    if (wr_go) mem[wr_addr] <= wr_data;
  end

  // Registered read port: real word, zero on underflow, hold when idle
  always_ff @(posedge clk_6M) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go)        rd_data <= mem[rd_addr];
      else if (|rd_hit) rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_sco_txbuf_pingpong.sv
// Testbench for sco_txbuf_pingpong: directed scenarios plus randomized
// traffic checked against a queue-style model of the ping/pong banks.
module tb_sco_txbuf_pingpong;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int NCH   = 3;
  localparam int CW    = 2;

  logic           clk_6M = 1'b0;
  logic           rst;
  logic [NCH-1:0] tsco_p;
  logic           wr_en;
  logic [CW-1:0]  wr_ch;
  logic [DW-1:0]  wr_data;
  logic           rd_en;
  logic [CW-1:0]  rd_ch;
  logic [DW-1:0]  rd_data;
  logic           rd_valid;
  logic [NCH-1:0] wr_full, rd_empty, ovf, udf, drop, err_clr;

  int checks = 0;
  int errors = 0;

  sco_txbuf_pingpong #(.DW(DW), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk_6M   (clk_6M),
    .rst      (rst),
    .tsco_p   (tsco_p),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_ch    (rd_ch),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_full  (wr_full),
    .rd_empty (rd_empty),
    .ovf      (ovf),
    .udf      (udf),
    .drop     (drop),
    .err_clr  (err_clr)
  );

  always #5 clk_6M = ~clk_6M;

  // Reference model: each bank is a list of words with a fill count,
  // the read bank additionally has a consume index.
  logic [DW-1:0]  m_w [NCH][DEPTH];
  logic [DW-1:0]  m_r [NCH][DEPTH];
  int             m_wn [NCH];
  int             m_rn [NCH];
  int             m_ri [NCH];
  logic [NCH-1:0] m_ovf, m_udf, m_drop;
  logic [DW-1:0]  m_data;
  logic           m_valid;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_wn[c] = 0;
      m_rn[c] = 0;
      m_ri[c] = 0;
    end
    m_ovf   = '0;
    m_udf   = '0;
    m_drop  = '0;
    m_data  = '0;
    m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] so, su, sd;
    int wc, rc;
    so = '0; su = '0; sd = '0;
    wc = int'(wr_ch);
    rc = int'(rd_ch);
    if (wr_en && wc < NCH) begin
      if (m_wn[wc] < DEPTH) begin
        m_w[wc][m_wn[wc]] = wr_data;
        m_wn[wc]++;
      end else so[wc] = 1'b1;
    end
    m_valid = 1'b0;
    if (rd_en && rc < NCH) begin
      if (m_ri[rc] < m_rn[rc]) begin
        m_data  = m_r[rc][m_ri[rc]];
        m_ri[rc]++;
        m_valid = 1'b1;
      end else begin
        m_data  = '0;
        su[rc]  = 1'b1;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (tsco_p[c]) begin
        if (m_ri[c] < m_rn[c]) sd[c] = 1'b1;
        for (int i = 0; i < m_wn[c]; i++) m_r[c][i] = m_w[c][i];
        m_rn[c] = m_wn[c];
        m_wn[c] = 0;
        m_ri[c] = 0;
      end
    end
    m_ovf  = so | (m_ovf  & ~err_clr);
    m_udf  = su | (m_udf  & ~err_clr);
    m_drop = sd | (m_drop & ~err_clr);
  endtask

  function automatic logic [NCH-1:0] m_full();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = (m_wn[c] == DEPTH);
    return r;
  endfunction

  function automatic logic [NCH-1:0] m_empty();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = (m_ri[c] == m_rn[c]);
    return r;
  endfunction

  // One clock: drive inputs, advance model, sample 1 time unit after the edge
  task automatic step(input logic [NCH-1:0] t, input logic we, input logic [CW-1:0] wc,
                      input logic [DW-1:0] wd, input logic re, input logic [CW-1:0] rc,
                      input logic [NCH-1:0] ec);
    tsco_p  = t;
    wr_en   = we;
    wr_ch   = wc;
    wr_data = wd;
    rd_en   = re;
    rd_ch   = rc;
    err_clr = ec;
    model_step();
    @(posedge clk_6M);
    #1;
    tsco_p  = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk_6M);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    if (wr_full !== 3'b000) begin errors++; $display("FAIL reset_wr_full got=%b exp=000", wr_full); end
    if (rd_empty !== 3'b111) begin errors++; $display("FAIL reset_rd_empty got=%b exp=111", rd_empty); end
    if ({ovf, udf, drop} !== 9'd0) begin errors++; $display("FAIL reset_flags got=%b exp=0", {ovf, udf, drop}); end
    step('0, 0, 0, 0, 1, 0, '0);
    checks += 3;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL udf_rd_valid got=%b exp=0", rd_valid); end
    if (rd_data !== '0) begin errors++; $display("FAIL udf_rd_data got=%h exp=0", rd_data); end
    if (udf !== 3'b001) begin errors++; $display("FAIL udf_set got=%b exp=001", udf); end
    step('0, 0, 0, 0, 0, 0, 3'b001);
    checks++;
    if (udf !== 3'b000) begin errors++; $display("FAIL udf_clr got=%b exp=000", udf); end
    // underflow coinciding with clear: the set must win
    step('0, 0, 0, 0, 1, 0, 3'b001);
    checks++;
    if (udf !== 3'b001) begin errors++; $display("FAIL clr_vs_set got=%b exp=001", udf); end
    step('0, 0, 0, 0, 0, 0, 3'b001);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) step('0, 1, 2'd1, DW'(32'hA0 + i), 0, 0, '0);
    step(3'b010, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      step('0, 0, 0, 0, 1, 2'd1, '0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== DW'(32'hA0 + i)) begin
        errors++;
        $display("FAIL stream_word%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, 32'hA0 + i);
      end
    end
    checks++;
    if (rd_empty[1] !== 1'b1) begin errors++; $display("FAIL stream_empty got=%b exp=1", rd_empty[1]); end
    step('0, 0, 0, 0, 0, 0, '0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'hA3) begin
      errors++;
      $display("FAIL stream_hold got=%b/%h exp=0/000000a3", rd_valid, rd_data);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp [DEPTH];
    logic [DW-1:0] wd;
    for (int i = 0; i <= DEPTH; i++) begin
      wd = $urandom;
      if (i < DEPTH) exp[i] = wd;
      step('0, 1, 2'd0, wd, 0, 0, '0);
      if (i == DEPTH - 2) begin
        checks++;
        if (wr_full[0] !== 1'b0) begin errors++; $display("FAIL ovf_notfull63 got=%b exp=0", wr_full[0]); end
      end
      if (i == DEPTH - 1) begin
        checks++;
        if (wr_full[0] !== 1'b1 || ovf[0] !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full64 got=full%b ovf%b exp=full1 ovf0", wr_full[0], ovf[0]);
        end
      end
      if (i == DEPTH) begin
        checks++;
        if (ovf[0] !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf[0]); end
      end
    end
    step(3'b001, 0, 0, 0, 0, 0, '0);
    checks++;
    if (wr_full[0] !== 1'b0 || rd_empty[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_swap got=full%b empty%b exp=full0 empty0", wr_full[0], rd_empty[0]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step('0, 0, 0, 0, 1, 2'd0, '0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp[i]) begin
        errors++;
        $display("FAIL ovf_read%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, exp[i]);
      end
    end
    step('0, 0, 0, 0, 1, 2'd0, '0);
    checks++;
    if (rd_valid !== 1'b0 || udf[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_read65 got=valid%b udf%b exp=valid0 udf1", rd_valid, udf[0]);
    end
    step('0, 0, 0, 0, 0, 0, '1);
    checks++;
    if ({ovf, udf, drop} !== 9'd0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", {ovf, udf, drop}); end
  endtask

  task automatic test_cross();
    logic [DW-1:0] e0 [8];
    logic [DW-1:0] e2 [8];
    for (int i = 0; i < 8; i++) begin
      e2[i] = $urandom;
      step('0, 1, 2'd2, e2[i], 0, 0, '0);
    end
    step(3'b100, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 8; i++) begin
      e0[i] = $urandom;
      step((i == 7) ? 3'b101 : 3'b000, 1, 2'd0, e0[i], 1, 2'd2, '0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e2[i]) begin
        errors++;
        $display("FAIL cross_ch2_%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, e2[i]);
      end
    end
    checks++;
    if (drop !== 3'b000 || rd_empty[2] !== 1'b1) begin
      errors++;
      $display("FAIL cross_swap got=drop%b empty2=%b exp=drop000 empty2=1", drop, rd_empty[2]);
    end
    for (int i = 0; i < 8; i++) begin
      step('0, 0, 0, 0, 1, 2'd0, '0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e0[i]) begin
        errors++;
        $display("FAIL cross_ch0_%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, e0[i]);
      end
    end
  endtask

  task automatic test_drop();
    logic [DW-1:0] e [4];
    for (int i = 0; i < 4; i++) begin
      e[i] = $urandom;
      step('0, 1, 2'd1, e[i], 0, 0, '0);
    end
    step(3'b010, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 2; i++) begin
      step('0, 0, 0, 0, 1, 2'd1, '0);
      checks++;
      if (rd_data !== e[i]) begin errors++; $display("FAIL drop_read%0d got=%h exp=%h", i, rd_data, e[i]); end
    end
    step(3'b010, 0, 0, 0, 0, 0, '0);
    checks++;
    if (drop !== 3'b010) begin errors++; $display("FAIL drop_set got=%b exp=010", drop); end
    step('0, 0, 0, 0, 0, 0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      e[i] = $urandom;
      step('0, 1, 2'd1, e[i], 0, 0, '0);
    end
    e[3] = $urandom;
    step(3'b010, 1, 2'd1, e[3], 0, 0, '0);
    checks++;
    if (drop !== 3'b000) begin errors++; $display("FAIL drop_none got=%b exp=000", drop); end
    for (int i = 0; i < 4; i++) begin
      step('0, 0, 0, 0, 1, 2'd1, '0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e[i]) begin
        errors++;
        $display("FAIL coinc_read%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, e[i]);
      end
    end
    checks++;
    if (rd_empty[1] !== 1'b1) begin errors++; $display("FAIL coinc_len got=%b exp=1", rd_empty[1]); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step('0, 1, 2'd0, DW'($urandom), 0, 0, '0);
    step(3'b001, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step('0, 0, 0, 0, 1, 2'd0, '0);
    step('0, 1, 2'd0, 32'h1234, 1, 2'd2, '0);
    checks++;
    if (udf[2] !== 1'b1 || rd_empty[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre got=udf2=%b empty0=%b exp=udf2=1 empty0=0", udf[2], rd_empty[0]);
    end
    rd_en = 1'b1;
    rd_ch = 2'd0;
    do_reset();
    rd_en = 1'b0;
    checks += 4;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid got=%b exp=0", rd_valid); end
    if ({ovf, udf, drop} !== 9'd0) begin errors++; $display("FAIL mid_flags got=%b exp=0", {ovf, udf, drop}); end
    if (rd_empty !== 3'b111) begin errors++; $display("FAIL mid_rd_empty got=%b exp=111", rd_empty); end
    if (wr_full !== 3'b000) begin errors++; $display("FAIL mid_wr_full got=%b exp=000", wr_full); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] t, ec;
    int lim;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      lim = (n < 1500) ? 40 : 400;
      for (int c = 0; c < NCH; c++) begin
        t[c]  = ($urandom_range(0, lim - 1) == 0);
        ec[c] = ($urandom_range(0, 99) == 0);
      end
      step(t, ($urandom_range(0, 3) != 0), CW'($urandom_range(0, 3)), DW'($urandom),
           ($urandom_range(0, 2) != 0), CW'($urandom_range(0, 3)), ec);
      checks++;
      if (rd_valid !== m_valid || rd_data !== m_data) begin
        errors++;
        $display("FAIL rnd_read cyc=%0d got=%b/%h exp=%b/%h", n, rd_valid, rd_data, m_valid, m_data);
      end
      checks++;
      if (wr_full !== m_full() || rd_empty !== m_empty()) begin
        errors++;
        $display("FAIL rnd_status cyc=%0d got=%b/%b exp=%b/%b", n, wr_full, rd_empty, m_full(), m_empty());
      end
      checks++;
      if (ovf !== m_ovf || udf !== m_udf || drop !== m_drop) begin
        errors++;
        $display("FAIL rnd_flags cyc=%0d got=%b/%b/%b exp=%b/%b/%b", n, ovf, udf, drop, m_ovf, m_udf, m_drop);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    tsco_p  = '0;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_data = '0;
    rd_en   = 1'b0;
    rd_ch   = '0;
    err_clr = '0;
    model_reset();
    test_reset();
    test_stream();
    test_overflow();
    test_cross();
    test_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
